// File: rtl/prog_sequence_detector.sv
// Serial bit-stream pattern detector with run-time loadable pattern, framed or
// sliding-window comparison, registered match pulse and saturating match counter.
module prog_sequence_detector #(
  parameter int                 PAT_W     = 4,
  parameter logic [PAT_W-1:0]   PAT_RESET = 4'b0110,
  parameter int                 CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       mode,
  input  logic                       pat_load,
  input  logic [PAT_W-1:0]           pat_in,
  input  logic                       count_clr,
  output logic                       match,
  output logic [CNT_W-1:0]           match_count,
  output logic [$clog2(PAT_W):0]     fill_lvl
);

  localparam int FW = $clog2(PAT_W) + 1;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;

  state_t             state;
  logic [PAT_W-1:0]   pattern;
  logic [PAT_W-1:0]   sr;
  logic               mode_q;

  logic [PAT_W-1:0]   word;
  logic               accept;
  logic               hit;

  // A bit is consumed only when no pattern load and no mode switch is pending.
  always_comb begin
    word   = {sr[PAT_W-2:0], in_bit};
    accept = in_valid && !pat_load && (mode == mode_q);
    hit    = accept && (fill_lvl >= FW'(PAT_W-1)) && (word == pattern);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      pattern     <= PAT_RESET;
      sr          <= '0;
      mode_q      <= 1'b0;
      fill_lvl    <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      mode_q <= mode;
      match  <= hit;

      if (pat_load)
        pattern <= pat_in;

      if (pat_load || (mode != mode_q)) begin
        fill_lvl <= '0;
        state    <= EMPTY;
      end else if (in_valid) begin
        sr <= word;
        if (!mode_q) begin
          // Framed: a completed block always restarts the frame.
          if (fill_lvl == FW'(PAT_W-1)) begin
            fill_lvl <= '0;
            state    <= EMPTY;
          end else begin
            fill_lvl <= fill_lvl + 1'b1;
            state    <= FILLING;
          end
        end else if (state != FULL) begin
          fill_lvl <= fill_lvl + 1'b1;
          state    <= (fill_lvl == FW'(PAT_W-1)) ? FULL : FILLING;
        end
      end

      if (count_clr)
        match_count <= '0;
      else if (hit && (match_count != '1))
        match_count <= match_count + 1'b1;
    end
  end

endmodule
